// File: rtl/pll_vga_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock with timeout/retry,
// then releases the pixel-domain reset; falls back to FAULT after repeated lock failures.
module pll_vga_reset_ctrl #(
    parameter int unsigned RST_HOLD_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] attempt
);

    localparam int unsigned CNT_W = 20;
    localparam int unsigned ATT_W = 4;

    localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(RST_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [ATT_W-1:0] ATT_ONE      = ATT_W'(1);
    localparam logic [ATT_W-1:0] ATT_MAX      = ATT_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ATT_W-1:0]   attempt_q, attempt_d;
    logic [1:0]         sync_q;
    logic               locked_s;
    logic               pll_rst_q, pll_rst_d;
    logic               sys_rst_n_q, sys_rst_n_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;

    // Two-flop synchronizer for the asynchronous lock flag
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign locked_s = sync_q[1];

    // State, shared counter, attempt and registered outputs
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET_PLL;
            cnt_q       <= HOLD_LOAD;
            attempt_q   <= ATT_ONE;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            attempt_q   <= attempt_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    // Next-state, counter and attempt logic; the counter exits a timed state when it reaches 1
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        attempt_d = attempt_q;
        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = TIMEOUT_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABILIZE;
                    cnt_d   = STABLE_LOAD;
                end else if (cnt_q <= CNT_ONE) begin
                    if (attempt_q < ATT_MAX) begin
                        state_d   = ST_RESET_PLL;
                        cnt_d     = HOLD_LOAD;
                        attempt_d = attempt_q + ATT_ONE;
                    end else begin
                        state_d = ST_FAULT;
                        cnt_d   = HOLD_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_STABILIZE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = TIMEOUT_LOAD;
                end else if (cnt_q <= CNT_ONE) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RUN: begin
                // Loss of lock and relock request share one path, so coincidence is harmless
                if (!locked_s || relock_req) begin
                    state_d   = ST_RESET_PLL;
                    cnt_d     = HOLD_LOAD;
                    attempt_d = ATT_ONE;
                end
            end
            ST_FAULT: begin
                if (relock_req) begin
                    state_d   = ST_RESET_PLL;
                    cnt_d     = HOLD_LOAD;
                    attempt_d = ATT_ONE;
                end
            end
            default: begin
                state_d   = ST_RESET_PLL;
                cnt_d     = HOLD_LOAD;
                attempt_d = ATT_ONE;
            end
        endcase
    end

    // Outputs decoded from the next state so the registers track the state exactly
    always_comb begin
        pll_rst_d   = 1'b0;
        sys_rst_n_d = 1'b0;
        ready_d     = 1'b0;
        fault_d     = 1'b0;
        case (state_d)
            ST_RESET_PLL: pll_rst_d = 1'b1;
            ST_RUN: begin
                sys_rst_n_d = 1'b1;
                ready_d     = 1'b1;
            end
            ST_FAULT: begin
                pll_rst_d = 1'b1;
                fault_d   = 1'b1;
            end
            default: pll_rst_d = 1'b0;
        endcase
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign attempt   = attempt_q;

endmodule

// File: tb/tb_pll_vga_reset_ctrl.sv
// Directed bench for pll_vga_reset_ctrl: nominal lock, glitch, loss+relock, timeout/fault,
// fault recovery and asynchronous reset, with hand-computed cycle counts.
module tb_pll_vga_reset_ctrl;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [3:0] attempt;

    int errors = 0;
    int checks = 0;

    always #10 refclk = ~refclk;

    pll_vga_reset_ctrl #(
        .RST_HOLD_CYCLES    (16),
        .LOCK_STABLE_CYCLES (1024),
        .LOCK_TIMEOUT_CYCLES(200),
        .MAX_RETRIES        (3)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .ready     (ready),
        .fault     (fault),
        .attempt   (attempt)
    );

    // One active edge, then park on the falling edge where inputs change and outputs are sampled
    task automatic tick();
        @(posedge refclk);
        @(negedge refclk);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        tick();
        tick();
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst: got %b expected 1", pll_rst); end
        checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL reset_sys_rst_n: got %b expected 0", sys_rst_n); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
        checks++; if (attempt !== 4'd1) begin errors++; $display("FAIL reset_attempt: got %0d expected 1", attempt); end
    endtask

    task automatic test_nominal();
        int n;
        rst_n = 1'b1;
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (n !== 16) begin errors++; $display("FAIL nominal_rst_hold: got %0d expected 16", n); end
        repeat (40) tick();
        checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL nominal_wait_sys_rst_n: got %b expected 0", sys_rst_n); end
        pll_locked = 1'b1;
        n = 0;
        while (sys_rst_n !== 1'b1 && n < 2000) begin tick(); n++; end
        checks++; if (n !== 1027) begin errors++; $display("FAIL nominal_latency: got %0d expected 1027", n); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL nominal_ready: got %b expected 1", ready); end
        checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL nominal_pll_rst: got %b expected 0", pll_rst); end
        checks++; if (attempt !== 4'd1) begin errors++; $display("FAIL nominal_attempt: got %0d expected 1", attempt); end
    endtask

    task automatic test_stabilize_glitch();
        int n;
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL relock_sys_rst_n: got %b expected 0", sys_rst_n); end
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL relock_pll_rst: got %b expected 1", pll_rst); end
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (n !== 16) begin errors++; $display("FAIL relock_rst_hold: got %0d expected 16", n); end
        repeat (501) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        n = 0;
        while (sys_rst_n !== 1'b1 && n < 2000) begin tick(); n++; end
        checks++; if (n !== 1027) begin errors++; $display("FAIL glitch_restart_latency: got %0d expected 1027", n); end
        checks++; if (attempt !== 4'd1) begin errors++; $display("FAIL glitch_attempt: got %0d expected 1", attempt); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL glitch_ready: got %b expected 1", ready); end
    endtask

    task automatic test_loss_with_relock();
        int n;
        pll_locked = 1'b0;
        tick();
        tick();
        checks++; if (sys_rst_n !== 1'b1) begin errors++; $display("FAIL loss_sync_delay: got %b expected 1", sys_rst_n); end
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL loss_sys_rst_n: got %b expected 0", sys_rst_n); end
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL loss_pll_rst: got %b expected 1", pll_rst); end
        checks++; if (attempt !== 4'd1) begin errors++; $display("FAIL loss_attempt: got %0d expected 1", attempt); end
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (n !== 16) begin errors++; $display("FAIL loss_rst_hold: got %0d expected 16", n); end
    endtask

    task automatic test_timeout_retry();
        int n;
        for (int a = 2; a <= 3; a++) begin
            n = 0;
            while (pll_rst === 1'b0 && n < 500) begin tick(); n++; end
            checks++; if (n !== 200) begin errors++; $display("FAIL timeout_wait_%0d: got %0d expected 200", a, n); end
            checks++; if (attempt !== 4'(a)) begin errors++; $display("FAIL timeout_attempt: got %0d expected %0d", attempt, a); end
            n = 0;
            while (pll_rst === 1'b1 && n < 100) begin tick(); n++; end
            checks++; if (n !== 16) begin errors++; $display("FAIL timeout_rst_hold_%0d: got %0d expected 16", a, n); end
        end
        n = 0;
        while (fault !== 1'b1 && n < 500) begin tick(); n++; end
        checks++; if (n !== 200) begin errors++; $display("FAIL fault_entry: got %0d expected 200", n); end
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL fault_pll_rst: got %b expected 1", pll_rst); end
        checks++; if (attempt !== 4'd3) begin errors++; $display("FAIL fault_attempt: got %0d expected 3", attempt); end
        repeat (50) tick();
        checks++; if (fault !== 1'b1 || sys_rst_n !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("FAIL fault_hold: got fault=%b sys_rst_n=%b ready=%b expected 1 0 0", fault, sys_rst_n, ready);
        end
        checks++; if (attempt !== 4'd3) begin errors++; $display("FAIL fault_attempt_hold: got %0d expected 3", attempt); end
    endtask

    task automatic test_fault_recovery();
        int n;
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        pll_locked = 1'b1;
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL recover_fault: got %b expected 0", fault); end
        checks++; if (attempt !== 4'd1) begin errors++; $display("FAIL recover_attempt: got %0d expected 1", attempt); end
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL recover_pll_rst: got %b expected 1", pll_rst); end
        n = 0;
        while (ready !== 1'b1 && n < 2000) begin tick(); n++; end
        checks++; if (n !== 1041) begin errors++; $display("FAIL recover_latency: got %0d expected 1041", n); end
        checks++; if (sys_rst_n !== 1'b1) begin errors++; $display("FAIL recover_sys_rst_n: got %b expected 1", sys_rst_n); end
    endtask

    task automatic test_async_reset();
        int n;
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin tick(); n++; end
        repeat (300) tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL async_pll_rst: got %b expected 1", pll_rst); end
        checks++; if (sys_rst_n !== 1'b0 || ready !== 1'b0 || fault !== 1'b0) begin
            errors++; $display("FAIL async_outputs: got sys_rst_n=%b ready=%b fault=%b expected 0 0 0", sys_rst_n, ready, fault);
        end
        checks++; if (attempt !== 4'd1) begin errors++; $display("FAIL async_attempt: got %0d expected 1", attempt); end
        repeat (3) @(negedge refclk);
        rst_n = 1'b1;
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (n !== 16) begin errors++; $display("FAIL async_restart_hold: got %0d expected 16", n); end
        n = 0;
        while (sys_rst_n !== 1'b1 && n < 2000) begin tick(); n++; end
        checks++; if (n !== 1025) begin errors++; $display("FAIL async_restart_latency: got %0d expected 1025", n); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stabilize_glitch();
        test_loss_with_relock();
        test_timeout_retry();
        test_fault_recovery();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
